// File: rtl/alarme_pkg.sv
// Shared types and constants for the alarm controller: state encodings,
// timer clear-bus codes and the saturating wrong-code counter helper.
package alarme_pkg;

  typedef enum logic [2:0] {
    DESARMADO = 3'd0,
    SAIDA     = 3'd1,
    ARMADO    = 3'd2,
    ENTRADA   = 3'd3,
    ALARME    = 3'd4
  } estado_t;

  localparam logic [2:0] TMR_RODA = 3'b000;
  localparam logic [2:0] TMR_ZERA = 3'b111;

  localparam int FALHAS_W = 2;
  typedef logic [FALHAS_W-1:0] falhas_t;

  function automatic falhas_t falhas_inc(input falhas_t f);
    return (f == '1) ? f : falhas_t'(f + 1'b1);
  endfunction

  // The timer only runs during the exit and entry delays.
  function automatic logic [2:0] tmr_decode(input estado_t e);
    return (e == SAIDA || e == ENTRADA) ? TMR_RODA : TMR_ZERA;
  endfunction

endpackage

// File: rtl/alarme_controle_if.sv
// Keypad, sensor and timer signals of the alarm controller, bundled with
// master (stimulus side) and slave (controller side) views. Optional panic input under ALARME_PANICO_EN.
interface alarme_controle_if
  import alarme_pkg::*;
#(
  parameter int NUM_SENSORES = 4,
  parameter int CODE_W       = 4
);
  logic [NUM_SENSORES-1:0] sensores;
  logic                    tecla_arm;
  logic                    tecla_ok;
  logic [CODE_W-1:0]       codigo;
  logic                    hab;
`ifdef ALARME_PANICO_EN
  logic                    panico;
`endif
  logic [2:0]              tmr_clr;
  logic [2:0]              estado;
  logic                    armado;
  logic                    sirene;
  logic [FALHAS_W-1:0]     falhas;
  logic [NUM_SENSORES-1:0] sensor_disparo;

`ifdef ALARME_PANICO_EN
  modport master (output sensores, tecla_arm, tecla_ok, codigo, hab, panico,
                  input  tmr_clr, estado, armado, sirene, falhas, sensor_disparo);
  modport slave  (input  sensores, tecla_arm, tecla_ok, codigo, hab, panico,
                  output tmr_clr, estado, armado, sirene, falhas, sensor_disparo);
`else
  modport master (output sensores, tecla_arm, tecla_ok, codigo, hab,
                  input  tmr_clr, estado, armado, sirene, falhas, sensor_disparo);
  modport slave  (input  sensores, tecla_arm, tecla_ok, codigo, hab,
                  output tmr_clr, estado, armado, sirene, falhas, sensor_disparo);
`endif

endinterface

// File: rtl/detector_borda.sv
// Rising-edge detector: registers the previous level, so a held level
// produces exactly one single-cycle event.
module detector_borda (
  input  logic clk,
  input  logic clr,
  input  logic x,
  output logic borda
);

  logic x_q;

  // NOTE: reset is synchronous and active-high here, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (clr) x_q <= 1'b0;
    else     x_q <= x;
  end

  assign borda = x & ~x_q;

endmodule

// File: rtl/alarme_controle.sv
// Arm/disarm controller: drives the 3-minute timer clear bus, the siren and
// the triggered-sensor record. Define ALARME_PANICO_EN to add the panic input.
module alarme_controle
  import alarme_pkg::*;
#(
  parameter int                NUM_SENSORES = 4,
  parameter int                CODE_W       = 4,
  parameter logic [CODE_W-1:0] CODIGO       = 4'hA,
  parameter int                MAX_TENT     = 3
) (
  input logic               clk,
  input logic               clr,
  alarme_controle_if.slave  bus
);

  logic arm_ev, ok_ev, hab_ev, panico_ev;

  detector_borda u_borda_arm (.clk(clk), .clr(clr), .x(bus.tecla_arm), .borda(arm_ev));
  detector_borda u_borda_ok  (.clk(clk), .clr(clr), .x(bus.tecla_ok),  .borda(ok_ev));
  detector_borda u_borda_hab (.clk(clk), .clr(clr), .x(bus.hab),       .borda(hab_ev));

`ifdef ALARME_PANICO_EN
  detector_borda u_borda_pan (.clk(clk), .clr(clr), .x(bus.panico),    .borda(panico_ev));
`else
  assign panico_ev = 1'b0;
`endif

  logic ok_certo, ok_errado;
  assign ok_certo  = ok_ev &  (bus.codigo == CODIGO);
  assign ok_errado = ok_ev & ~(bus.codigo == CODIGO);

  estado_t                 estado_q, estado_d;
  falhas_t                 falhas_q, falhas_d;
  logic [NUM_SENSORES-1:0] disparo_q, disparo_d;
  logic [2:0]              tmr_clr_q;
  logic                    armado_q, sirene_q;

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    estado_d  = estado_q;
    falhas_d  = falhas_q;
    disparo_d = disparo_q;

    if (panico_ev) begin
      // Panic alarms immediately and leaves the attempt count and sensor record untouched.
      estado_d = ALARME;
    end else begin
      if (estado_q == ARMADO || estado_q == ENTRADA || estado_q == ALARME)
        disparo_d = disparo_q | bus.sensores;

      if (ok_certo) begin
        estado_d  = DESARMADO;
        falhas_d  = '0;
        disparo_d = '0;
      end else begin
        case (estado_q)
          DESARMADO: begin
            if (arm_ev && bus.sensores == '0) begin
              estado_d = SAIDA;
              falhas_d = '0;
            end
          end
          SAIDA: begin
            if (hab_ev) estado_d = ARMADO;
          end
          ARMADO: begin
            if (|bus.sensores) estado_d = ENTRADA;
          end
          ENTRADA: begin
            if (ok_errado) begin
              falhas_d = falhas_inc(falhas_q);
              if (int'(falhas_d) >= MAX_TENT || hab_ev) estado_d = ALARME;
            end else if (hab_ev) begin
              estado_d = ALARME;
            end
          end
          ALARME: begin
            if (ok_errado) falhas_d = falhas_inc(falhas_q);
          end
          default: begin
            estado_d  = DESARMADO;
            disparo_d = '0;
          end
        endcase
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      estado_q  <= DESARMADO;
      falhas_q  <= '0;
      disparo_q <= '0;
      tmr_clr_q <= TMR_ZERA;
      armado_q  <= 1'b0;
      sirene_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      falhas_q  <= falhas_d;
      disparo_q <= disparo_d;
      tmr_clr_q <= tmr_decode(estado_d);
      armado_q  <= (estado_d == ARMADO || estado_d == ENTRADA || estado_d == ALARME);
      sirene_q  <= (estado_d == ALARME);
    end
  end

  assign bus.estado         = estado_q;
  assign bus.falhas         = falhas_q;
  assign bus.sensor_disparo = disparo_q;
  assign bus.tmr_clr        = tmr_clr_q;
  assign bus.armado         = armado_q;
  assign bus.sirene         = sirene_q;

endmodule

// File: tb/tb_alarme_controle.sv
// Self-checking bench for alarme_controle: vector table plus timer-driven
// sequences, with expected outputs queued in a scoreboard.
module tb_alarme_controle;
  import alarme_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  alarme_controle_if #(.NUM_SENSORES(4), .CODE_W(4)) bus ();

  alarme_controle #(
    .NUM_SENSORES(4),
    .CODE_W      (4),
    .CODIGO      (4'hA),
    .MAX_TENT    (3)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  // Timer model: counts while the clear bus is released, flags expiry at tmr_lim.
  logic       use_timer = 1'b0;
  logic       hab_tbl   = 1'b0;
  int         tmr_lim   = 8;
  logic [7:0] tmr_cnt   = 8'd0;

  always_ff @(posedge clk) begin
    if (bus.tmr_clr == 3'b111)  tmr_cnt <= 8'd0;
    else if (tmr_cnt != 8'hFF)  tmr_cnt <= tmr_cnt + 8'd1;
  end

  always_comb bus.hab = use_timer ? (int'(tmr_cnt) >= tmr_lim) : hab_tbl;

  typedef struct {
    logic [2:0] st;
    logic [2:0] tmr;
    logic       armado;
    logic       sirene;
    logic [1:0] f;
    logic [3:0] d;
  } exp_t;

  typedef struct {
    logic [3:0] sens;
    logic       arm;
    logic       ok;
    logic [3:0] cod;
    logic       hab;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk_exp(input logic [2:0] st, input logic [1:0] f, input logic [3:0] d);
    exp_t e;
    e.st     = st;
    e.tmr    = (st == 3'd1 || st == 3'd3) ? 3'b000 : 3'b111;
    e.armado = (st == 3'd2 || st == 3'd3 || st == 3'd4);
    e.sirene = (st == 3'd4);
    e.f      = f;
    e.d      = d;
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] sens, input logic arm, input logic ok,
                              input logic [3:0] cod, input logic hab,
                              input logic [2:0] st, input logic [1:0] f, input logic [3:0] d);
    vec_t v;
    v.sens = sens; v.arm = arm; v.ok = ok; v.cod = cod; v.hab = hab;
    v.e    = mk_exp(st, f, d);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    e = sb.pop_front();
    check({tag, "_estado"},  {5'd0, bus.estado},         {5'd0, e.st});
    check({tag, "_tmr_clr"}, {5'd0, bus.tmr_clr},        {5'd0, e.tmr});
    check({tag, "_armado"},  {7'd0, bus.armado},         {7'd0, e.armado});
    check({tag, "_sirene"},  {7'd0, bus.sirene},         {7'd0, e.sirene});
    check({tag, "_falhas"},  {6'd0, bus.falhas},         {6'd0, e.f});
    check({tag, "_disparo"}, {4'd0, bus.sensor_disparo}, {4'd0, e.d});
  endtask

  task automatic drive(input logic [3:0] sens, input logic arm, input logic ok,
                       input logic [3:0] cod, input logic hab);
    bus.sensores  = sens;
    bus.tecla_arm = arm;
    bus.tecla_ok  = ok;
    bus.codigo    = cod;
    hab_tbl       = hab;
`ifdef ALARME_PANICO_EN
    bus.panico    = 1'b0;
`endif
  endtask

  task automatic step(input logic [3:0] sens, input logic arm, input logic ok,
                      input logic [3:0] cod, input logic hab, input exp_t e, input string tag);
    drive(sens, arm, ok, cod, hab);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic wait_estado(input logic [2:0] target, input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      if (bus.estado == target) break;
      @(posedge clk);
      #1;
    end
    check(name, {5'd0, bus.estado}, {5'd0, target});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1;
    drive(4'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd0, 2'd0, 4'b0), "reset0");
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd0, 2'd0, 4'b0), "reset1");
    clr = 1'b0;

    //             sens     arm ok cod  hab  st f  disparo
    tbl.push_back(mk(4'b0010, 1, 0, 4'h0, 0, 0, 0, 4'b0000)); // arm blocked by open sensor
    tbl.push_back(mk(4'b0000, 1, 0, 4'h0, 0, 0, 0, 4'b0000)); // held key: no new edge
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 1, 0, 4'h0, 0, 1, 0, 4'b0000)); // arm -> exit delay
    tbl.push_back(mk(4'b0000, 0, 1, 4'h5, 0, 1, 0, 4'b0000)); // wrong code ignored in SAIDA
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 1, 2, 0, 4'b0000)); // expiry -> armed
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 2, 0, 4'b0000));
    tbl.push_back(mk(4'b0100, 0, 0, 4'h0, 0, 3, 0, 4'b0100)); // sensor -> entry delay
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 3, 0, 4'b0100));
    tbl.push_back(mk(4'b0000, 0, 1, 4'hA, 0, 0, 0, 4'b0000)); // correct code disarms
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 1, 0, 4'h0, 1, 1, 0, 4'b0000)); // enter SAIDA with hab already high
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 1, 1, 0, 4'b0000)); // stale hab is not expiry
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 1, 2, 0, 4'b0000));
    tbl.push_back(mk(4'b1000, 0, 0, 4'h0, 0, 3, 0, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 1, 4, 0, 4'b1000)); // entry timeout -> alarm
    tbl.push_back(mk(4'b0000, 0, 1, 4'h3, 0, 4, 1, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 4, 1, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 1, 4'h5, 0, 4, 2, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 4, 2, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 1, 4'h5, 0, 4, 3, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 4, 3, 4'b1000));
    tbl.push_back(mk(4'b0000, 0, 1, 4'h5, 0, 4, 3, 4'b1000)); // counter saturates
    tbl.push_back(mk(4'b0001, 0, 0, 4'h0, 0, 4, 3, 4'b1001)); // alarm keeps recording
    tbl.push_back(mk(4'b0000, 0, 1, 4'hA, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 1, 0, 4'h0, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 1, 2, 0, 4'b0000));
    tbl.push_back(mk(4'b0010, 0, 0, 4'h0, 0, 3, 0, 4'b0010));
    tbl.push_back(mk(4'b0000, 0, 1, 4'h7, 1, 4, 1, 4'b0010)); // wrong code + expiry together
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 4, 1, 4'b0010));
    tbl.push_back(mk(4'b0000, 0, 1, 4'hA, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 0, 0, 4'h0, 0, 0, 0, 4'b0000));

    foreach (tbl[i])
      step(tbl[i].sens, tbl[i].arm, tbl[i].ok, tbl[i].cod, tbl[i].hab, tbl[i].e,
           $sformatf("row%0d", i));

    // Wrong-code attempts with the timer model; a long hold counts once.
    use_timer = 1'b1;
    tmr_lim   = 60;
    step(4'b0, 1, 0, 4'h0, 0, mk_exp(3'd1, 2'd0, 4'b0), "seqA_arm");
    drive(4'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_estado(3'd2, 100, "seqA_exit_expiry");
    step(4'b0100, 0, 0, 4'h0, 0, mk_exp(3'd3, 2'd0, 4'b0100), "seqA_entry");
    for (int i = 0; i < 10; i++)
      step(4'b0, 0, 1, 4'h5, 0, mk_exp(3'd3, 2'd1, 4'b0100), $sformatf("seqA_hold%0d", i));
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd3, 2'd1, 4'b0100), "seqA_rel1");
    step(4'b0, 0, 1, 4'h5, 0, mk_exp(3'd3, 2'd2, 4'b0100), "seqA_try2");
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd3, 2'd2, 4'b0100), "seqA_rel2");
    step(4'b0, 0, 1, 4'h5, 0, mk_exp(3'd4, 2'd3, 4'b0100), "seqA_try3");
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd4, 2'd3, 4'b0100), "seqA_rel3");
    step(4'b0, 0, 1, 4'hA, 0, mk_exp(3'd0, 2'd0, 4'b0),    "seqA_disarm");
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd0, 2'd0, 4'b0),    "seqA_idle");

    // Reset while alarming with two failed attempts recorded.
    tmr_lim = 6;
    step(4'b0, 1, 0, 4'h0, 0, mk_exp(3'd1, 2'd0, 4'b0), "seqB_arm");
    drive(4'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_estado(3'd2, 40, "seqB_exit_expiry");
    step(4'b0001, 0, 0, 4'h0, 0, mk_exp(3'd3, 2'd0, 4'b0001), "seqB_entry");
    drive(4'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_estado(3'd4, 40, "seqB_entry_expiry");
    step(4'b0, 0, 1, 4'h3, 0, mk_exp(3'd4, 2'd1, 4'b0001), "seqB_bad1");
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd4, 2'd1, 4'b0001), "seqB_rel1");
    step(4'b0, 0, 1, 4'h3, 0, mk_exp(3'd4, 2'd2, 4'b0001), "seqB_bad2");
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd4, 2'd2, 4'b0001), "seqB_rel2");
    clr = 1'b1;
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd0, 2'd0, 4'b0), "seqB_clr");
    clr = 1'b0;
    step(4'b0, 0, 0, 4'h0, 0, mk_exp(3'd0, 2'd0, 4'b0), "seqB_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarme_controle.md
# alarme_controle

Arm/disarm controller of the residential security system, directly upstream and downstream of the 3‑minute timer. Drives the timer's 3‑bit clear bus to start the exit and entry delays, and consumes the timer's `hab` expiry flag. Turns keypad strobes, code entry and door/window/PIR sensor levels into the system state, the siren output and a latched record of which sensors fired.

## Interface
- `NUM_SENSORES`, 4: number of sensor inputs.
- `CODE_W`, 4: width of the disarm code.
- `CODIGO`, 4'hA: correct disarm code, `CODE_W` bits.
- `MAX_TENT`, 3: wrong-code attempts that force alarm during entry delay; range 1..3.

Ports:
- `clk` input 1: system clock. The block has one clock domain.
- `clr` input 1: reset, synchronous, active-high.
- `sensores` input `NUM_SENSORES`: sensor levels; 1 means open or motion.
- `tecla_arm` input 1: arm key level from the debounced keypad.
- `tecla_ok` input 1: confirm key level; submits `codigo`.
- `codigo` input `CODE_W`: code digits; sampled on the `tecla_ok` rising edge.
- `hab` input 1: timer expiry flag, level.
- `tmr_clr` output 3: timer clear bus. 3'b111 holds the timer at zero; 3'b000 lets it count.
- `estado` output 3: state code.
- `armado` output 1: high in ARMADO, ENTRADA and ALARME.
- `sirene` output 1: high in ALARME.
- `falhas` output 2: wrong-code counter, saturating.
- `sensor_disparo` output `NUM_SENSORES`: latched OR of the sensors that triggered.

## Operation
- Edge detection:
  - `tecla_arm`, `tecla_ok` and `hab` each have a registered previous value.
  - An event is `x & ~x_q`. A held level counts once.
- Code check: `ok_certo` = `tecla_ok` edge & (`codigo == CODIGO`). `ok_errado` = `tecla_ok` edge & mismatch.
- State machine, with `estado` encoding:
  - DESARMADO (0): `arm` edge with `sensores == 0` → SAIDA. `arm` edge with any sensor high is ignored.
  - SAIDA (1), exit delay: `ok_certo` → DESARMADO. `hab` edge → ARMADO.
  - ARMADO (2): `ok_certo` → DESARMADO. Any `sensores` bit high → ENTRADA.
  - ENTRADA (3), entry delay:
    - `ok_certo` → DESARMADO.
    - `hab` edge → ALARME.
    - `ok_errado` increments `falhas`. If the new value reaches `MAX_TENT` → ALARME.
  - ALARME (4): only `ok_certo` → DESARMADO. `ok_errado` increments `falhas` (saturating).
  - Encodings 5–7 are illegal and recover to DESARMADO on the next clock.
- `tmr_clr`: 3'b000 in SAIDA and ENTRADA, 3'b111 in every other state. It is decoded from the state register, so the timer is always zero when a delay begins.
- `falhas`:
  - Cleared on every `ok_certo`, on entering SAIDA, and on reset.
  - Saturates at 3.
  - Increments only in ENTRADA and ALARME. In other states `ok_errado` is ignored.
- `sensor_disparo`:
  - In ARMADO, ENTRADA and ALARME it ORs in `sensores` each clock.
  - It is cleared on entering DESARMADO.
- Priorities within one cycle:
  - `clr` > panic (if compiled in) > `ok_certo` > `ok_errado` > `hab` edge > sensors.
  - `ok_errado` together with a `hab` edge in ENTRADA → ALARME, and `falhas` still increments.
- Reset values: `estado`=0, `tmr_clr`=3'b111, `armado`=0, `sirene`=0, `falhas`=0, `sensor_disparo`=0, all edge registers 0.
- `clr` asserted mid-delay or mid-alarm returns everything to the reset values on the next edge.

## Timing
- Every transition takes effect on the clock edge after the cycle in which the triggering edge or level is present, so latency is 1 clock.
- All outputs are registered or decoded from registers. There is no combinational input→output path.
- `tmr_clr` changes in the same cycle as `estado`. Because the timer clears one edge later, `hab` falls 1 clock after the block leaves SAIDA or ENTRADA.
- `hab` that is already high when entering a delay state does not count as expiry; a fresh rising edge is required.

## Configuration
- `ALARME_PANICO_EN` defined:
  - Adds input `panico` (1 bit, level).
  - A rising edge of `panico` → ALARME from any state, including DESARMADO.
  - In that case `sensor_disparo` is unchanged and `falhas` is unchanged.
- `ALARME_PANICO_EN` undefined: the `panico` port and its logic are absent.

## Structure
- Package `alarme_pkg` holds:
  - the state encodings DESARMADO..ALARME;
  - the `tmr_clr` constants TMR_RODA=3'b000 and TMR_ZERA=3'b111;
  - `falhas` width 2.
- Sub-module `detector_borda` (registered previous value, rising-edge output, synchronous reset). It is instantiated three times, four with `ALARME_PANICO_EN`.

## Test plan
All scenarios use `NUM_SENSORES`=4, `CODIGO`=4'hA, `MAX_TENT`=3, with the bench modelling the timer.

- Arm and exit: `tecla_arm` pulse with sensors 0 → `estado`=1, `tmr_clr`=000. `hab` rises → `estado`=2, `armado`=1, `tmr_clr`=111.
- Arm blocked: `sensores`=4'b0010 plus `tecla_arm` → `estado` stays 0 and `tmr_clr` stays 111.
- Entry then disarm:
  - In ARMADO, `sensores`=4'b0100 for 1 clock → `estado`=3, `sensor_disparo`=4'b0100.
  - Then `codigo`=4'hA with `tecla_ok` → `estado`=0 and `sensor_disparo`=0.
- Entry timeout: ENTRADA with no keys, `hab` rises → `estado`=4, `sirene`=1. Then `tecla_ok` with 4'h3 → `falhas`=1 and `sirene` stays 1.
- Wrong codes: in ENTRADA, three `tecla_ok` pulses with 4'h5 → the third gives `estado`=4. `tecla_ok` held for 10 clocks counts as one attempt.
- Reset mid-alarm: `clr` high in ALARME with `falhas`=2 → next clock all outputs are at reset values and `tmr_clr`=111.
